universal_register: RTL and testbench

UNIVERSAL_REGISTER -- requirements
Module: universal_register

---
 rtl/universal_register_pkg.sv | 18 +
 rtl/ur_next_state.sv | 79 +++++++
 rtl/universal_register.sv | 48 ++++
 tb/tb_universal_register.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/universal_register_pkg.sv
// Shared mode encodings for the universal register.
// Imported by the register top and its next-state logic.
package universal_register_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_INC  = 3'd6,
    MODE_DEC  = 3'd7
  } mode_e;

  localparam int MODE_W = 3;

endpackage

// File: rtl/ur_next_state.sv
// Combinational next value and carry for the universal register.
// Extended-width helper vectors keep WIDTH=1 legal without generates.
module ur_next_state
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  cur_o,
  input  logic              cur_carry,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  nxt_o,
  output logic              nxt_carry
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  mode_e          m;
  logic [WIDTH:0] shl_w;
  logic [WIDTH:0] shr_w;
  logic [WIDTH:0] rol_w;
  logic [WIDTH:0] ror_w;
  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;

  assign m     = mode_e'(mode);
  assign shl_w = {cur_o, sin};
  assign shr_w = {sin, cur_o};
  assign rol_w = {cur_o, cur_o[WIDTH-1]};
  assign ror_w = {cur_o[0], cur_o};
  assign inc_w = {1'b0, cur_o} + ONE;
  // top bit of the extended difference is the borrow out of zero
  assign dec_w = {1'b0, cur_o} - ONE;

  always_comb begin
    nxt_o     = cur_o;
    nxt_carry = cur_carry;
    unique case (1'b1)
      (m == MODE_HOLD): begin
        nxt_o     = cur_o;
        nxt_carry = cur_carry;
      end
      (m == MODE_LOAD): begin
        nxt_o     = d;
        nxt_carry = 1'b0;
      end
      (m == MODE_SHL): begin
        nxt_o     = shl_w[WIDTH-1:0];
        nxt_carry = shl_w[WIDTH];
      end
      (m == MODE_SHR): begin
        nxt_o     = shr_w[WIDTH:1];
        nxt_carry = shr_w[0];
      end
      (m == MODE_ROL): begin
        nxt_o     = rol_w[WIDTH-1:0];
        nxt_carry = rol_w[WIDTH];
      end
      (m == MODE_ROR): begin
        nxt_o     = ror_w[WIDTH:1];
        nxt_carry = ror_w[0];
      end
      (m == MODE_INC): begin
        nxt_o     = inc_w[WIDTH-1:0];
        nxt_carry = inc_w[WIDTH];
      end
      (m == MODE_DEC): begin
        nxt_o     = dec_w[WIDTH-1:0];
        nxt_carry = dec_w[WIDTH];
      end
      default: begin
        nxt_o     = cur_o;
        nxt_carry = cur_carry;
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// Universal register: load, shift, rotate, inc/dec with carry flag.
// Holds the only state (o, carry); next values come from ur_next_state.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  o,
  output logic              carry,
  output logic              zero
);

  logic [WIDTH-1:0] nxt_o;
  logic             nxt_carry;

  ur_next_state #(
    .WIDTH(WIDTH)
  ) u_next (
    .cur_o    (o),
    .cur_carry(carry),
    .mode     (mode),
    .d        (d),
    .sin      (sin),
    .nxt_o    (nxt_o),
    .nxt_carry(nxt_carry)
  );

  // st gates the update so a floating mode cannot reach the flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o     <= RESET_VALUE;
      carry <= 1'b0;
    end else if (st) begin
      o     <= nxt_o;
      carry <= nxt_carry;
    end
  end

  assign zero = (o == '0);

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: vector table, corner sequences,
// WIDTH=1 instance and randomized run against an arithmetic model.
module tb_universal_register;

  logic       clk = 1'b0;
  logic       rst, st, sin;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] o;
  logic       carry, zero;

  logic       rst1, st1, sin1, d1;
  logic [2:0] mode1;
  logic       o1, carry1, zero1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .st(st), .mode(mode), .d(d), .sin(sin),
    .o(o), .carry(carry), .zero(zero)
  );

  universal_register #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .st(st1), .mode(mode1), .d(d1), .sin(sin1),
    .o(o1), .carry(carry1), .zero(zero1)
  );

  typedef struct {
    logic       r;
    logic       s;
    logic [2:0] m;
    logic [7:0] dd;
    logic       si;
    logic [7:0] eo;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic s, int m, int dd, logic si,
                              int eo, logic ec);
    vec_t v;
    v.r  = r;
    v.s  = s;
    v.m  = 3'(m);
    v.dd = 8'(dd);
    v.si = si;
    v.eo = 8'(eo);
    v.ec = ec;
    v.ez = (eo == 0);
    return v;
  endfunction

  int mo, mc;

  // behavioural model of one enabled operation, plain arithmetic
  task automatic model_op(input int m, input int dv, input int si);
    int old;
    old = mo;
    case (m)
      1: begin mo = dv; mc = 0; end
      2: begin mo = (old * 2 + si) % 256; mc = old / 128; end
      3: begin mo = old / 2 + si * 128; mc = old % 2; end
      4: begin mo = (old * 2) % 256 + old / 128; mc = old / 128; end
      5: begin mo = old / 2 + (old % 2) * 128; mc = old % 2; end
      6: begin mo = (old + 1) % 256; mc = (old == 255) ? 1 : 0; end
      7: begin mo = (old + 255) % 256; mc = (old == 0) ? 1 : 0; end
      default: ;
    endcase
  endtask

  initial begin
    rst = 0; st = 0; mode = 0; d = 0; sin = 0;
    rst1 = 0; st1 = 0; mode1 = 0; d1 = 0; sin1 = 0;
    #2;
    rst = 1; rst1 = 1;
    #1;
    chk("reset_o", 64'(o), 64'h00);
    chk("reset_carry", 64'(carry), 64'h0);
    chk("reset_zero", 64'(zero), 64'h1);

    tbl.push_back(mk(1, 1, 1, 8'h55, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 8'h81, 0, 8'h81, 0));
    tbl.push_back(mk(0, 1, 2, 8'h00, 0, 8'h02, 1));
    tbl.push_back(mk(0, 1, 3, 8'h00, 1, 8'h81, 0));
    tbl.push_back(mk(0, 1, 4, 8'h00, 0, 8'h03, 1));
    tbl.push_back(mk(0, 1, 5, 8'h00, 0, 8'h81, 1));
    tbl.push_back(mk(0, 0, 1, 8'h3C, 1, 8'h81, 1));
    tbl.push_back(mk(0, 1, 0, 8'h3C, 1, 8'h81, 1));
    tbl.push_back(mk(0, 1, 1, 8'hFF, 0, 8'hFF, 0));
    tbl.push_back(mk(0, 1, 6, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 7, 8'h00, 0, 8'hFF, 1));
    tbl.push_back(mk(0, 1, 7, 8'h00, 0, 8'hFE, 0));
    for (int m = 0; m < 8; m++)
      tbl.push_back(mk(0, 0, m, (m % 2) ? 8'hAA : 8'h55, m[0],
                       8'hFE, 0));
    tbl.push_back(mk(0, 1, 0, 8'h12, 1, 8'hFE, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst  = tbl[i].r;
      st   = tbl[i].s;
      mode = tbl[i].m;
      d    = tbl[i].dd;
      sin  = tbl[i].si;
      step();
      chk($sformatf("vec%0d_o", i), 64'(o), 64'(tbl[i].eo));
      chk($sformatf("vec%0d_carry", i), 64'(carry), 64'(tbl[i].ec));
      chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(tbl[i].ez));
    end

    // async reset mid-run with o=A5, carry=1
    st = 1; mode = 1; d = 8'hD2;
    step();
    mode = 2; sin = 1;
    step();
    chk("pre_rst_o", 64'(o), 64'hA5);
    chk("pre_rst_carry", 64'(carry), 64'h1);
    st = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_o", 64'(o), 64'h00);
    chk("async_rst_carry", 64'(carry), 64'h0);
    chk("async_rst_zero", 64'(zero), 64'h1);
    st = 1; mode = 6;
    step();
    chk("rst_held_o", 64'(o), 64'h00);
    rst = 0;
    step();
    chk("first_op_after_rst", 64'(o), 64'h01);

    // WIDTH=1, RESET_VALUE=1
    rst1 = 0;
    step();
    rst1 = 1;
    #1;
    chk("w1_reset_o", 64'(o1), 64'h1);
    chk("w1_reset_carry", 64'(carry1), 64'h0);
    chk("w1_reset_zero", 64'(zero1), 64'h0);
    rst1 = 0; st1 = 1; mode1 = 2; sin1 = 0;
    step();
    chk("w1_shl_o", 64'(o1), 64'h0);
    chk("w1_shl_carry", 64'(carry1), 64'h1);
    chk("w1_shl_zero", 64'(zero1), 64'h1);
    mode1 = 6;
    step();
    chk("w1_inc1_o", 64'(o1), 64'h1);
    chk("w1_inc1_carry", 64'(carry1), 64'h0);
    step();
    chk("w1_inc2_o", 64'(o1), 64'h0);
    chk("w1_inc2_carry", 64'(carry1), 64'h1);
    mode1 = 4; sin1 = 1;
    step();
    chk("w1_rol_o", 64'(o1), 64'h0);
    chk("w1_rol_carry", 64'(carry1), 64'h0);
    mode1 = 1; d1 = 1;
    step();
    mode1 = 5; sin1 = 0;
    step();
    chk("w1_ror_o", 64'(o1), 64'h1);
    chk("w1_ror_carry", 64'(carry1), 64'h1);
    mode1 = 3; sin1 = 0;
    step();
    chk("w1_shr_o", 64'(o1), 64'h0);
    chk("w1_shr_carry", 64'(carry1), 64'h1);
    mode1 = 7;
    step();
    chk("w1_dec_o", 64'(o1), 64'h1);
    chk("w1_dec_carry", 64'(carry1), 64'h1);
    st1 = 0;

    // randomized run against the arithmetic model
    rst = 1; st = 0;
    step();
    rst = 0;
    mo = 0; mc = 0;
    for (int i = 0; i < 600; i++) begin
      int m, dv, si, se;
      m  = $urandom_range(0, 7);
      dv = $urandom_range(0, 255);
      si = $urandom_range(0, 1);
      se = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1;
        #1;
        chk($sformatf("rnd%0d_async_rst", i), 64'(o), 64'h00);
        mo = 0; mc = 0;
      end else begin
        rst = 0;
        if (se == 1) model_op(m, dv, si);
      end
      st   = se[0];
      mode = 3'(m);
      d    = 8'(dv);
      sin  = si[0];
      step();
      chk($sformatf("rnd%0d_o", i), 64'(o), 64'(mo));
      chk($sformatf("rnd%0d_carry", i), 64'(carry), 64'(mc));
      chk($sformatf("rnd%0d_zero", i), 64'(zero), (mo == 0) ? 64'h1 : 64'h0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
